// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types.
// Contents: arbiter state encoding, one-hot grant record, line geometry constants.
package lc3b_types;

   localparam int unsigned LINE_OFFSET_BITS = 4;
   localparam int unsigned LINE_ADDR_BITS   = 12;
   localparam int unsigned LINE_DATA_BITS   = 128;

   typedef enum logic [2:0] {
      IDLE,
      I_RD,
      D_RD,
      WB_WR,
      BREAK
   } arb_state_t;

   // One-hot grant from the arbiter pick logic; all-zero means no grant.
   typedef struct packed {
      logic wb;
      logic d;
      logic i;
   } arb_grant_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection for the memory arbiter.
// Ports: i_read/d_read/wb_req (requests), i_addr/d_addr/wb_addr (line addresses),
//        rr_ptr (0 = I-cache preferred), starve_cnt (reads granted past a waiting EWB),
//        grant (one-hot winner, zero when nobody requests).
module arb_pick
   import lc3b_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                      i_read,
   input  logic                      d_read,
   input  logic                      wb_req,
   input  logic [LINE_ADDR_BITS-1:0] i_addr,
   input  logic [LINE_ADDR_BITS-1:0] d_addr,
   input  logic [LINE_ADDR_BITS-1:0] wb_addr,
   input  logic                      rr_ptr,
   input  logic [3:0]                starve_cnt,
   output arb_grant_t                grant
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic hazard;

   // A pending write to a line being read must land first, or the read returns stale data.
   assign hazard = wb_req && ((d_read && (d_addr == wb_addr)) ||
                              (i_read && (i_addr == wb_addr)));

   always_comb begin
      grant = '0;
      if (hazard) begin
         grant.wb = 1'b1;
      end else if (wb_req && (starve_cnt >= LIMIT)) begin
         grant.wb = 1'b1;
      end else if (i_read && d_read) begin
         if (!rr_ptr) grant.i = 1'b1;
         else         grant.d = 1'b1;
      end else if (i_read) begin
         grant.i = 1'b1;
      end else if (d_read) begin
         grant.d = 1'b1;
      end else if (wb_req) begin
         grant.wb = 1'b1;
      end
   end

endmodule

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-low clear.
// Ports: clk, rst_n (async, active-low), load (capture enable),
//        in (next value), out (held value, 0 after reset).
module register #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else if (load) begin
         out <= in;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Physical-memory port arbiter between I-cache fills, D-cache fills and EWB drain.
// Ports: clk, rst_n (async, active-low);
//        i_read/i_addr -> i_rdata/i_resp   I-cache line read;
//        d_read/d_addr -> d_rdata/d_resp   D-cache line read;
//        wb_req/wb_addr/wb_wdata -> wb_ack EWB line write;
//        pmem_read/pmem_write/pmem_address/pmem_wdata, pmem_rdata/pmem_resp to memory.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_read,
   input  logic [11:0]   i_addr,
   output logic [127:0]  i_rdata,
   output logic          i_resp,
   input  logic          d_read,
   input  logic [11:0]   d_addr,
   output logic [127:0]  d_rdata,
   output logic          d_resp,
   input  logic          wb_req,
   input  logic [11:0]   wb_addr,
   input  logic [127:0]  wb_wdata,
   output logic          wb_ack,
   output logic          pmem_read,
   output logic          pmem_write,
   output logic [15:0]   pmem_address,
   output logic [127:0]  pmem_wdata,
   input  logic [127:0]  pmem_rdata,
   input  logic          pmem_resp
);

   arb_state_t                state, state_next;
   logic                      rr_ptr;
   logic [3:0]                starve_cnt;
   arb_grant_t                grant;
   logic                      in_idle;
   logic [LINE_ADDR_BITS-1:0] addr_sel;
   logic [LINE_ADDR_BITS-1:0] addr_q;
   logic [LINE_DATA_BITS-1:0] wdata_q;

   assign in_idle  = (state == IDLE);
   assign addr_sel = grant.wb ? wb_addr : (grant.d ? d_addr : i_addr);

   arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .i_read     (i_read),
      .d_read     (d_read),
      .wb_req     (wb_req),
      .i_addr     (i_addr),
      .d_addr     (d_addr),
      .wb_addr    (wb_addr),
      .rr_ptr     (rr_ptr),
      .starve_cnt (starve_cnt),
      .grant      (grant)
   );

   register #(
      .WIDTH (LINE_ADDR_BITS)
   ) u_addr_q (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_idle && (grant != '0)),
      .in    (addr_sel),
      .out   (addr_q)
   );

   register #(
      .WIDTH (LINE_DATA_BITS)
   ) u_wdata_q (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_idle && grant.wb),
      .in    (wb_wdata),
      .out   (wdata_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         starve_cnt <= '0;
      end else begin
         state <= state_next;
         if (pmem_resp && (state == I_RD)) rr_ptr <= 1'b1;
         if (pmem_resp && (state == D_RD)) rr_ptr <= 1'b0;
         if (in_idle) begin
            if (!wb_req || grant.wb) begin
               starve_cnt <= '0;
            end else if ((grant.i || grant.d) && (starve_cnt != 4'hF)) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end
      end
   end

   // Address and write data come straight from the latched registers, so they
   // hold their last value outside a transfer and read 0 after reset.
   assign pmem_address = {addr_q, {LINE_OFFSET_BITS{1'b0}}};
   assign pmem_wdata   = wdata_q;

   always_comb begin
      state_next = state;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      wb_ack     = 1'b0;
      i_rdata    = '0;
      d_rdata    = '0;
      case (state)
         IDLE: begin
            if (grant.wb)     state_next = WB_WR;
            else if (grant.i) state_next = I_RD;
            else if (grant.d) state_next = D_RD;
         end
         I_RD: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               i_resp     = 1'b1;
               i_rdata    = pmem_rdata;
               state_next = BREAK;
            end
         end
         D_RD: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               d_resp     = 1'b1;
               d_rdata    = pmem_rdata;
               state_next = BREAK;
            end
         end
         WB_WR: begin
            pmem_write = 1'b1;
            if (pmem_resp) begin
               wb_ack     = 1'b1;
               state_next = BREAK;
            end
         end
         BREAK:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule
